infifo_thread_scheduler: RTL and testbench
==========================================

// Module: infifo_thread_scheduler
// PURPOSE
//  Sequences packets from the shared small input FIFO into per-thread input FIFOs.
//  Picks a free thread round-robin and drives the per-thread write strobes.
//  Hands the packet to that thread's CPU with a one-cycle enable pulse.
//  Sits between the small input FIFO (first-word-fall-through) and the per-thread input FIFOs.
// PARAMETERS
//  NUM_THREADS  8   number of threads/FIFOs; 2..8 legal; thread index is 3 bits
//  MAX_BEATS    256 longest legal packet in beats; longer packets are truncated
// PORTS
//  clk              in  1   system clock
//  reset            in  1   synchronous, active-high reset
//  pkt_valid        in  1   small FIFO not empty; head beat visible
//  pkt_firstword    in  1   head beat is the first word of a packet
//  pkt_lastword     in  1   head beat is the last word of a packet
//  thread_busy      in  NT  per-thread busy (1 = thread owns its FIFO)
//  smallfifo_rd_en  out 1   pop head beat of the small FIFO
//  thread_sel       out 3   thread currently receiving a packet
//  thread_sel_next  out 3   thread to be granted next (round-robin candidate)
//  fifowrite_out    out NT  one-hot write strobe to the selected thread's FIFO
//  firstword_out    out NT  one-hot first-word flag to the selected thread's FIFO
//  enable_cpu_out   out NT  one-hot, one-cycle packet hand-off pulse
//  pkt_cnt          out 16  packets handed off; wraps at 2^16
//  drop_cnt         out 16  beats discarded plus truncations; saturates at 0xFFFF
// BEHAVIOUR
//  Reset (sync, any state, mid-packet included):
//   - state=IDLE; thread_sel=0; last grant ptr=NUM_THREADS-1, so the first grant is thread 0.
//   - All strobes 0; pending mask 0; pkt_cnt=0; drop_cnt=0; beat_cnt=0.
//  Eligibility:
//   - elig[i] = ~thread_busy[i] & ~pending[i], for i<NUM_THREADS.
//   - thread_sel_next is combinational: the first elig thread scanning ptr+1, ptr+2, ... modulo NUM_THREADS.
//   - If no thread is eligible, thread_sel_next holds ptr+1 (mod NT).
//  FSM IDLE / DRAIN / XFER / HANDOFF:
//   IDLE
//    - pkt_valid & ~pkt_firstword -> DRAIN. The stray beat is not popped in this cycle.
//    - pkt_valid & pkt_firstword & |elig -> XFER. Latch thread_sel and ptr from thread_sel_next; no pop this cycle.
//    - No eligible thread: stay in IDLE, rd_en=0. This is back-pressure; the packet is held.
//   DRAIN
//    - rd_en=pkt_valid & ~pkt_firstword; drop_cnt += 1 per popped beat.
//    - Returns to IDLE when the head is a firstword or the FIFO is empty.
//   XFER
//    - rd_en = fifowrite_out[thread_sel] = pkt_valid (same cycle, zero latency).
//    - firstword_out[thread_sel] = pkt_valid & (beat_cnt==0).
//    - beat_cnt increments per popped beat.
//    - Popped beat with pkt_lastword, or beat_cnt==MAX_BEATS-1 -> HANDOFF.
//    - On truncation: drop_cnt += 1, and the remainder of the packet is removed by a later DRAIN.
//    - pkt_firstword seen at beat_cnt>0 is written as a data beat; it is not treated as a new packet.
//   HANDOFF (1 cycle)
//    - enable_cpu_out[thread_sel]=1; pending[thread_sel]<=1; pkt_cnt += 1; beat_cnt<=0; -> IDLE.
//  pending[i] clears on the first cycle thread_busy[i]=1. This covers the 1-cycle busy latency.
//  The minimum gap between two packets is 2 cycles: HANDOFF, then the IDLE grant.
//  All strobes other than bit thread_sel are 0. Every *_out vector is at most one-hot.
//  Bits >= NUM_THREADS are tied to 0.
//  thread_busy dropping mid-XFER has no effect; the packet completes.
// TESTING
//  - Reset, all threads idle, 3-beat packet -> thread_sel=0.
//    fifowrite_out=0x01 for 3 cycles, firstword_out=0x01 on beat 0 only.
//    enable_cpu_out=0x01 one cycle after the last beat; pkt_cnt=1.
//  - 8 back-to-back 1-beat packets, thread_busy follows enable with 1-cycle delay
//    -> grants 0,1,...,7 in order. A 9th packet stalls (rd_en=0) until thread_busy[0] clears, then goes to thread 0.
//  - thread_busy=0xFB (only thread 2 free), ptr=5 -> thread_sel_next=2.
//    Packet goes to thread 2; the next packet waits while pending[2] is set.
//  - 3 stray non-firstword beats, then a valid packet -> drop_cnt=3 and the packet is delivered intact.
//  - MAX_BEATS=4, 6-beat packet -> 4 beats written, handoff, drop_cnt=1.
//    2 trailing beats drained (drop_cnt=3).
//  - Reset asserted at beat 2 of 5 -> next cycle all outputs 0 and state IDLE.
//    Remaining beats are drained as strays; the next packet goes to thread 0.

Source files
------------

// File: rtl/infifo_thread_scheduler.sv
// infifo_thread_scheduler
//   Moves packets from the shared first-word-fall-through small input FIFO into
//   the per-thread input FIFOs. A free thread is picked round-robin, the packet
//   is streamed into that thread's FIFO with zero latency, and the thread's CPU
//   receives a one-cycle enable pulse once the packet is complete.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   pkt_valid           small FIFO not empty, head beat visible
//   pkt_firstword       head beat starts a packet
//   pkt_lastword        head beat ends a packet
//   thread_busy         per-thread busy (1 = thread owns its FIFO)
//   smallfifo_rd_en     pop the small FIFO head
//   thread_sel          thread currently receiving a packet
//   thread_sel_next     round-robin candidate for the next grant
//   fifowrite_out       one-hot write strobe to the selected thread FIFO
//   firstword_out       one-hot first-word flag to the selected thread FIFO
//   enable_cpu_out      one-hot, one-cycle packet hand-off pulse
//   pkt_cnt             packets handed off (wraps)
//   drop_cnt            discarded beats plus truncations (saturates)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a first word and an eligible thread
// DRAIN   | popping and discarding stray non-first beats
// XFER    | streaming beats into the selected thread FIFO
// HANDOFF | one-cycle CPU enable pulse, mark thread pending

module infifo_thread_scheduler #(
  parameter int NUM_THREADS = 8,
  parameter int MAX_BEATS   = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_valid,
  input  logic                   pkt_firstword,
  input  logic                   pkt_lastword,
  input  logic [NUM_THREADS-1:0] thread_busy,
  output logic                   smallfifo_rd_en,
  output logic [2:0]             thread_sel,
  output logic [2:0]             thread_sel_next,
  output logic [NUM_THREADS-1:0] fifowrite_out,
  output logic [NUM_THREADS-1:0] firstword_out,
  output logic [NUM_THREADS-1:0] enable_cpu_out,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
  localparam logic [2:0]    PTR_RST   = 3'(NUM_THREADS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_HANDOFF = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [2:0]             sel_q, sel_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [NUM_THREADS-1:0] pending_q, pending_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [15:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] sel_oh;
  logic [2:0]             nxt;
  logic                   drop_inc;

  // Round-robin pick: the eligible thread with the smallest forward distance
  // from the last grant (distance 1..NUM_THREADS, so the last grant itself is
  // considered last).
  always_comb begin
    int best;
    int d;
    elig = ~thread_busy & ~pending_q;
    best = NUM_THREADS + 1;
    d    = 0;
    nxt  = (int'(ptr_q) + 1 >= NUM_THREADS) ? 3'd0 : ptr_q + 3'd1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (elig[i]) begin
        d = (i > int'(ptr_q)) ? (i - int'(ptr_q)) : (i + NUM_THREADS - int'(ptr_q));
        if (d < best) begin
          best = d;
          nxt  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      sel_oh[i] = (sel_q == 3'(i));
    end
  end

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    ptr_d           = ptr_q;
    beat_d          = beat_q;
    pkt_cnt_d       = pkt_cnt_q;
    pending_d       = pending_q & ~thread_busy;
    drop_inc        = 1'b0;
    smallfifo_rd_en = 1'b0;
    fifowrite_out   = '0;
    firstword_out   = '0;
    enable_cpu_out  = '0;

    case (state_q)
      S_IDLE: begin
        // Stray beats go to DRAIN first; they are popped from there.
        if (pkt_valid && !pkt_firstword) begin
          state_d = S_DRAIN;
        end else if (pkt_valid && pkt_firstword && (|elig)) begin
          state_d = S_XFER;
          sel_d   = nxt;
          ptr_d   = nxt;
          beat_d  = '0;
        end
      end
      S_DRAIN: begin
        smallfifo_rd_en = pkt_valid & ~pkt_firstword;
        drop_inc        = smallfifo_rd_en;
        if (!smallfifo_rd_en) begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        smallfifo_rd_en = pkt_valid;
        fifowrite_out   = sel_oh & {NUM_THREADS{pkt_valid}};
        firstword_out   = sel_oh & {NUM_THREADS{pkt_valid && (beat_q == '0)}};
        if (pkt_valid) begin
          beat_d = beat_q + BW'(1);
          if (pkt_lastword) begin
            state_d = S_HANDOFF;
          end else if (beat_q == LAST_BEAT) begin
            // Truncated: the rest of the packet arrives as strays and is drained.
            state_d  = S_HANDOFF;
            drop_inc = 1'b1;
          end
        end
      end
      default: begin
        enable_cpu_out = sel_oh;
        pending_d      = (pending_q & ~thread_busy) | sel_oh;
        pkt_cnt_d      = pkt_cnt_q + 16'd1;
        beat_d         = '0;
        state_d        = S_IDLE;
      end
    endcase

    drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 3'd0;
      ptr_q      <= PTR_RST;
      pending_q  <= '0;
      beat_q     <= '0;
      pkt_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign thread_sel      = sel_q;
  assign thread_sel_next = nxt;
  assign pkt_cnt         = pkt_cnt_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_infifo_thread_scheduler.sv
module tb_infifo_thread_scheduler;

  localparam int NT = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pkt_valid = 1'b0;
  logic          pkt_firstword = 1'b0;
  logic          pkt_lastword = 1'b0;
  logic [NT-1:0] thread_busy = '0;
  logic          smallfifo_rd_en;
  logic [2:0]    thread_sel;
  logic [2:0]    thread_sel_next;
  logic [NT-1:0] fifowrite_out;
  logic [NT-1:0] firstword_out;
  logic [NT-1:0] enable_cpu_out;
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;

  infifo_thread_scheduler #(.NUM_THREADS(NT), .MAX_BEATS(MB)) dut (
    .clk             (clk),
    .reset           (reset),
    .pkt_valid       (pkt_valid),
    .pkt_firstword   (pkt_firstword),
    .pkt_lastword    (pkt_lastword),
    .thread_busy     (thread_busy),
    .smallfifo_rd_en (smallfifo_rd_en),
    .thread_sel      (thread_sel),
    .thread_sel_next (thread_sel_next),
    .fifowrite_out   (fifowrite_out),
    .firstword_out   (firstword_out),
    .enable_cpu_out  (enable_cpu_out),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {bit f; bit l;} beat_t;
  typedef struct {bit ho; int thr; bit first;} exp_t;

  beat_t in_q[$];
  exp_t  exp_q[$];

  int      checks = 0;
  int      errors = 0;
  int      wr_seen = 0;
  int      ho_seen = 0;
  logic [NT-1:0] busy_model = '0;
  bit      auto_busy = 1'b1;
  bit      rd_sample = 1'b0;

  function automatic logic [NT-1:0] oh(input int t);
    logic [NT-1:0] v;
    v = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  // Small-FIFO model, busy model and output monitor. Inputs change at the
  // falling edge; outputs are sampled 2 time units later, well before the
  // rising edge.
  initial begin : drv_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_sample && in_q.size() > 0) void'(in_q.pop_front());
      thread_busy = busy_model;
      if (in_q.size() > 0) begin
        pkt_valid     = 1'b1;
        pkt_firstword = in_q[0].f;
        pkt_lastword  = in_q[0].l;
      end else begin
        pkt_valid     = 1'b0;
        pkt_firstword = 1'b0;
        pkt_lastword  = 1'b0;
      end
      #2;
      rd_sample = smallfifo_rd_en;
      if (fifowrite_out != '0) begin
        wr_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write fifowrite_out=%h firstword_out=%h (none expected)",
                   fifowrite_out, firstword_out);
        end else begin
          e = exp_q.pop_front();
          if (e.ho || fifowrite_out != oh(e.thr) ||
              firstword_out != (e.first ? oh(e.thr) : '0) ||
              thread_sel != 3'(e.thr) || !smallfifo_rd_en) begin
            errors++;
            $display("FAIL write_beat got wr=%h fw=%h sel=%0d rd=%0b, want ho=%0b thr=%0d first=%0b",
                     fifowrite_out, firstword_out, thread_sel, smallfifo_rd_en,
                     e.ho, e.thr, e.first);
          end
        end
      end
      if (enable_cpu_out != '0) begin
        ho_seen++;
        checks++;
        if (auto_busy) busy_model = busy_model | enable_cpu_out;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_handoff enable_cpu_out=%h (none expected)", enable_cpu_out);
        end else begin
          e = exp_q.pop_front();
          if (!e.ho || enable_cpu_out != oh(e.thr)) begin
            errors++;
            $display("FAIL handoff got en=%h, want ho=%0b thr=%0d", enable_cpu_out, e.ho, e.thr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic push_pkt(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.f = (i == 0);
      b.l = (i == n - 1);
      in_q.push_back(b);
    end
  endtask

  task automatic push_stray(input int n);
    beat_t b;
    b.f = 1'b0;
    b.l = 1'b0;
    for (int i = 0; i < n; i++) in_q.push_back(b);
  endtask

  task automatic expect_wr(input int thr, input int n, input int first_idx);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.ho    = 1'b0;
      e.thr   = thr;
      e.first = (i == first_idx);
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_ho(input int thr);
    exp_t e;
    e.ho    = 1'b1;
    e.thr   = thr;
    e.first = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < bound) begin
      cyc(1);
      n++;
    end
    if (exp_q.size() != 0 || in_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout exp_left=%0d beats_left=%0d", name, exp_q.size(), in_q.size());
      exp_q.delete();
      in_q.delete();
    end
    cyc(3);
  endtask

  task automatic do_reset();
    busy_model = '0;
    auto_busy  = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #3;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    chk("rst_rd_en", 32'(smallfifo_rd_en), 0);
    chk("rst_thread_sel", 32'(thread_sel), 0);
    chk("rst_sel_next", 32'(thread_sel_next), 0);
    chk("rst_fifowrite", 32'(fifowrite_out), 0);
    chk("rst_enable", 32'(enable_cpu_out), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);

    // 3-beat packet to thread 0
    push_pkt(3);
    expect_wr(0, 3, 0);
    expect_ho(0);
    wait_done("t1_pkt", 50);
    chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t1_thread_sel", 32'(thread_sel), 0);

    // 8 back-to-back packets, 9th stalls until thread 0 frees
    do_reset();
    base = ho_seen;
    for (int t = 0; t < 8; t++) begin
      push_pkt(1);
      expect_wr(t, 1, 0);
      expect_ho(t);
    end
    push_pkt(1);
    n = 0;
    while (ho_seen < base + 8 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t2_handoffs", 32'(ho_seen - base), 8);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t2_stall_rd_en", 32'(smallfifo_rd_en), 0);
    end
    chk("t2_stall_sel_next", 32'(thread_sel_next), 0);
    chk("t2_stall_pkt_cnt", 32'(pkt_cnt), 8);
    chk("t2_head_held", 32'(in_q.size()), 1);
    expect_wr(0, 1, 0);
    expect_ho(0);
    busy_model = busy_model & ~oh(0);
    wait_done("t2_ninth", 50);
    chk("t2_pkt_cnt", 32'(pkt_cnt), 9);
    chk("t2_ninth_sel", 32'(thread_sel), 0);

    // Only thread 2 free with ptr=5; then pending[2] blocks thread 2
    do_reset();
    for (int t = 0; t < 6; t++) begin
      push_pkt(1);
      expect_wr(t, 1, 0);
      expect_ho(t);
    end
    wait_done("t3_warmup", 100);
    auto_busy  = 1'b0;
    busy_model = 8'hFB;
    cyc(2);
    chk("t3_sel_next_2", 32'(thread_sel_next), 2);
    push_pkt(2);
    expect_wr(2, 2, 0);
    expect_ho(2);
    wait_done("t3_pkt2", 50);
    push_pkt(1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t3_pending_rd_en", 32'(smallfifo_rd_en), 0);
    end
    chk("t3_pending_sel_next", 32'(thread_sel_next), 3);
    expect_wr(3, 1, 0);
    expect_ho(3);
    busy_model = 8'hF3;
    wait_done("t3_pkt3", 50);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 8);

    // 3 stray beats then a packet
    do_reset();
    push_stray(3);
    push_pkt(2);
    expect_wr(0, 2, 0);
    expect_ho(0);
    wait_done("t4_stray", 50);
    chk("t4_drop_cnt", 32'(drop_cnt), 3);
    chk("t4_pkt_cnt", 32'(pkt_cnt), 1);

    // Truncation at MAX_BEATS=4, then an exactly-4-beat packet
    do_reset();
    push_pkt(6);
    expect_wr(0, 4, 0);
    expect_ho(0);
    wait_done("t5_trunc", 60);
    chk("t5_drop_cnt", 32'(drop_cnt), 3);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 1);
    push_pkt(4);
    expect_wr(1, 4, 0);
    expect_ho(1);
    wait_done("t5_exact", 50);
    chk("t5_exact_drop_cnt", 32'(drop_cnt), 3);
    chk("t5_exact_pkt_cnt", 32'(pkt_cnt), 2);

    // Reset during beat 2 of a 5-beat packet
    do_reset();
    base = wr_seen;
    push_pkt(5);
    push_pkt(1);
    expect_wr(0, 3, 0);
    expect_wr(0, 1, 0);
    expect_ho(0);
    n = 0;
    while (wr_seen < base + 2 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("t6_beats_before_rst", 32'(wr_seen - base), 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("t6_rd_en", 32'(smallfifo_rd_en), 0);
    chk("t6_fifowrite", 32'(fifowrite_out), 0);
    chk("t6_firstword", 32'(firstword_out), 0);
    chk("t6_enable", 32'(enable_cpu_out), 0);
    chk("t6_thread_sel", 32'(thread_sel), 0);
    chk("t6_pkt_cnt_rst", 32'(pkt_cnt), 0);
    wait_done("t6_after_rst", 60);
    chk("t6_drop_cnt", 32'(drop_cnt), 2);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t6_thread_sel_final", 32'(thread_sel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
